// File: rtl/bsg_cache_sbuf_pkg.sv
// Shared types for the store-buffer drain arbiter: entry layout macro and arbiter state.
`ifndef BSG_CACHE_SBUF_ENTRY_S_DEFINED
`define BSG_CACHE_SBUF_ENTRY_S_DEFINED
`define BSG_CACHE_SBUF_ENTRY_S(aw, dw, lgw) \
    typedef struct packed { \
        logic [(aw)-1:0]     addr; \
        logic [(dw)-1:0]     data; \
        logic [((dw)/8)-1:0] mask; \
        logic [(lgw)-1:0]    way_id; \
    } bsg_cache_sbuf_entry_s
`endif

package bsg_cache_sbuf_pkg;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        FORCE  = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } sbuf_arb_state_e;

endpackage

// File: rtl/bsg_cache_sbuf_starve_ctr.sv
// Saturating starvation counter; limit_reached looks at the value being loaded this cycle.
module bsg_cache_sbuf_starve_ctr
    import bsg_cache_sbuf_pkg::*;
#(
    parameter int limit_p = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic limit_reached
);

    localparam int width_lp = $clog2(limit_p + 1);
    localparam logic [width_lp-1:0] limit_lp = width_lp'(limit_p);

    logic [width_lp-1:0] cnt_r, cnt_n;

    always_comb begin
        cnt_n = cnt_r;
        if (clr)
            cnt_n = '0;
        else if (inc && (cnt_r != limit_lp))
            cnt_n = cnt_r + width_lp'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_r <= '0;
        else
            cnt_r <= cnt_n;
    end

    // Next-value compare lets the arbiter enter FORCE right after the limit-th read win.
    assign limit_reached = (cnt_n == limit_lp);

endmodule

// File: rtl/bsg_cache_sbuf_drain_arb.sv
// Shares the single-ported data memory between pipeline reads and store-buffer drains,
// with starvation-forced drains and a drain-to-empty flush sequence.
module bsg_cache_sbuf_drain_arb
    import bsg_cache_sbuf_pkg::*;
#(
    parameter int addr_width_p   = 28,
    parameter int data_width_p   = 32,
    parameter int ways_p         = 2,
    parameter int starve_limit_p = 4,
    localparam int lg_ways_lp         = $clog2(ways_p),
    localparam int mask_width_lp      = data_width_p / 8,
    localparam int byte_off_lp        = $clog2(mask_width_lp),
    localparam int word_addr_width_lp = addr_width_p - byte_off_lp,
    localparam int entry_width_lp     = addr_width_p + data_width_p + mask_width_lp + lg_ways_lp
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          sbuf_v_i,
    input  logic [entry_width_lp-1:0]     sbuf_entry_i,
    input  logic                          sbuf_empty_i,
    output logic                          sbuf_yumi_o,
    input  logic                          rd_v_i,
    input  logic [addr_width_p-1:0]       rd_addr_i,
    input  logic [lg_ways_lp-1:0]         rd_way_i,
    output logic                          rd_yumi_o,
    input  logic                          flush_v_i,
    output logic                          flush_done_o,
    output logic                          dm_v_o,
    output logic                          dm_w_o,
    output logic [word_addr_width_lp-1:0] dm_addr_o,
    output logic [lg_ways_lp-1:0]         dm_way_o,
    output logic [data_width_p-1:0]       dm_data_o,
    output logic [mask_width_lp-1:0]      dm_mask_o
);

    `BSG_CACHE_SBUF_ENTRY_S(addr_width_p, data_width_p, lg_ways_lp);

    bsg_cache_sbuf_entry_s entry;
    sbuf_arb_state_e       state_r, state_n;
    logic                  starve_hit, ctr_inc, ctr_clr;
    logic                  unused;

    assign entry  = sbuf_entry_i;
    assign unused = ^{entry.addr[byte_off_lp-1:0], rd_addr_i[byte_off_lp-1:0]};

    always_ff @(posedge clk_i) begin
        if (reset_i)
            state_r <= NORMAL;
        else
            state_r <= state_n;
    end

    always_comb begin
        state_n = state_r;
        case (state_r)
            NORMAL: begin
                if (flush_v_i)
                    state_n = FLUSH;
                else if (starve_hit)
                    state_n = FORCE;
            end
            FORCE:   state_n = NORMAL;
            FLUSH:   if (sbuf_empty_i && !sbuf_yumi_o) state_n = DONE;
            DONE:    state_n = NORMAL;
            default: state_n = NORMAL;
        endcase
    end

    // No grants while reset is held so nothing reaches the memory port from the reset cycle.
    always_comb begin
        rd_yumi_o    = 1'b0;
        sbuf_yumi_o  = 1'b0;
        flush_done_o = 1'b0;
        if (!reset_i) begin
            case (state_r)
                NORMAL: begin
                    rd_yumi_o   = rd_v_i;
                    sbuf_yumi_o = sbuf_v_i & ~rd_v_i;
                end
                FORCE, FLUSH: sbuf_yumi_o  = sbuf_v_i;
                DONE:         flush_done_o = 1'b1;
                default: ;
            endcase
        end
    end

    assign ctr_inc = (state_r == NORMAL) & sbuf_v_i & rd_v_i & ~reset_i;
    assign ctr_clr = sbuf_yumi_o | ~sbuf_v_i;

    bsg_cache_sbuf_starve_ctr #(
        .limit_p(starve_limit_p)
    ) starve_ctr (
        .clk          (clk_i),
        .reset        (reset_i),
        .inc          (ctr_inc),
        .clr          (ctr_clr),
        .limit_reached(starve_hit)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            dm_v_o    <= 1'b0;
            dm_w_o    <= 1'b0;
            dm_addr_o <= '0;
            dm_way_o  <= '0;
            dm_data_o <= '0;
            dm_mask_o <= '0;
        end else begin
            dm_v_o <= sbuf_yumi_o | rd_yumi_o;
            if (sbuf_yumi_o) begin
                dm_w_o    <= 1'b1;
                dm_addr_o <= entry.addr[addr_width_p-1:byte_off_lp];
                dm_way_o  <= entry.way_id;
                dm_data_o <= entry.data;
                dm_mask_o <= entry.mask;
            end else if (rd_yumi_o) begin
                dm_w_o    <= 1'b0;
                dm_addr_o <= rd_addr_i[addr_width_p-1:byte_off_lp];
                dm_way_o  <= rd_way_i;
                dm_data_o <= '0;
                dm_mask_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bsg_cache_sbuf_drain_arb.sv
// Scenario bench for the drain arbiter; memory-port accesses are checked against an expected-access queue.
module tb_bsg_cache_sbuf_drain_arb;

    localparam int AW  = 28;
    localparam int DW  = 32;
    localparam int MW  = DW / 8;
    localparam int LW  = 1;
    localparam int EW  = AW + DW + MW + LW;
    localparam int WAW = AW - 2;

    typedef struct packed {
        logic           w;
        logic [WAW-1:0] addr;
        logic [LW-1:0]  way;
        logic [DW-1:0]  data;
        logic [MW-1:0]  mask;
    } acc_t;

    logic           clk = 1'b0;
    logic           reset_i, sbuf_v_i, sbuf_empty_i, rd_v_i, flush_v_i;
    logic [EW-1:0]  sbuf_entry_i;
    logic [AW-1:0]  rd_addr_i;
    logic [LW-1:0]  rd_way_i;
    logic           sbuf_yumi_o, rd_yumi_o, flush_done_o, dm_v_o, dm_w_o;
    logic [WAW-1:0] dm_addr_o;
    logic [LW-1:0]  dm_way_o;
    logic [DW-1:0]  dm_data_o;
    logic [MW-1:0]  dm_mask_o;

    acc_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    bsg_cache_sbuf_drain_arb #(
        .addr_width_p(AW), .data_width_p(DW), .ways_p(2), .starve_limit_p(4)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .sbuf_v_i(sbuf_v_i), .sbuf_entry_i(sbuf_entry_i), .sbuf_empty_i(sbuf_empty_i),
        .sbuf_yumi_o(sbuf_yumi_o),
        .rd_v_i(rd_v_i), .rd_addr_i(rd_addr_i), .rd_way_i(rd_way_i), .rd_yumi_o(rd_yumi_o),
        .flush_v_i(flush_v_i), .flush_done_o(flush_done_o),
        .dm_v_o(dm_v_o), .dm_w_o(dm_w_o), .dm_addr_o(dm_addr_o), .dm_way_o(dm_way_o),
        .dm_data_o(dm_data_o), .dm_mask_o(dm_mask_o)
    );

    function automatic logic [EW-1:0] ent(logic [AW-1:0] a, logic [DW-1:0] d, logic [MW-1:0] m, logic [LW-1:0] w);
        return {a, d, m, w};
    endfunction

    function automatic acc_t wr_acc(logic [AW-1:0] a, logic [DW-1:0] d, logic [MW-1:0] m, logic [LW-1:0] w);
        return {1'b1, a[AW-1:2], w, d, m};
    endfunction

    function automatic acc_t rd_acc(logic [AW-1:0] a, logic [LW-1:0] w);
        return {1'b0, a[AW-1:2], w, {DW{1'b0}}, {MW{1'b0}}};
    endfunction

    // Every memory-port access must match the oldest outstanding expectation.
    always @(negedge clk) begin
        acc_t got, exp;
        if (dm_v_o === 1'b1) begin
            got = {dm_w_o, dm_addr_o, dm_way_o, dm_data_o, dm_mask_o};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL dm_unexpected: got %h, required no access", got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    n_bad++;
                    $display("FAIL dm_access: got %h, required %h", got, exp);
                end
            end
        end
    end

    task automatic idle(input int n);
        rd_v_i = 1'b0; sbuf_v_i = 1'b0; flush_v_i = 1'b0; sbuf_empty_i = 1'b1;
        repeat (n) begin
            @(negedge clk);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1; rd_v_i = 1'b1; sbuf_v_i = 1'b1; sbuf_empty_i = 1'b0; flush_v_i = 1'b0;
        sbuf_entry_i = ent(28'h0000ABC, 32'h12345678, 4'hF, 1'b1);
        rd_addr_i = 28'h0000040; rd_way_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({rd_yumi_o, sbuf_yumi_o} !== 2'b00) begin
            n_bad++; $display("FAIL reset_grants: got %b, required 00", {rd_yumi_o, sbuf_yumi_o});
        end
        n_cmp++;
        if ({dm_v_o, dm_w_o, flush_done_o} !== 3'b000) begin
            n_bad++; $display("FAIL reset_ctrl: got %b, required 000", {dm_v_o, dm_w_o, flush_done_o});
        end
        n_cmp++;
        if ({dm_addr_o, dm_way_o, dm_data_o, dm_mask_o} !== {(WAW+LW+DW+MW){1'b0}}) begin
            n_bad++; $display("FAIL reset_data: got %h, required 0", {dm_addr_o, dm_way_o, dm_data_o, dm_mask_o});
        end
        @(posedge clk); #1;
        reset_i = 1'b0;
        idle(1);
    endtask

    task automatic test_reads_only();
        sbuf_v_i = 1'b0; sbuf_empty_i = 1'b1; rd_v_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rd_addr_i = AW'(32'h0000800 + i * 4);
            rd_way_i  = LW'(i % 2);
            exp_q.push_back(rd_acc(rd_addr_i, rd_way_i));
            @(negedge clk);
            n_cmp++;
            if ({rd_yumi_o, sbuf_yumi_o} !== 2'b10) begin
                n_bad++; $display("FAIL reads_grant[%0d]: got %b, required 10", i, {rd_yumi_o, sbuf_yumi_o});
            end
            if (i >= 1) begin
                n_cmp++;
                if (dm_v_o !== 1'b1) begin
                    n_bad++; $display("FAIL reads_dm_v[%0d]: got %b, required 1", i, dm_v_o);
                end
            end
            @(posedge clk); #1;
        end
        idle(2);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL reads_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_starve();
        int  k = 0;
        bit  exp_sb;
        rd_v_i = 1'b1; sbuf_v_i = 1'b1; sbuf_empty_i = 1'b0;
        for (int i = 0; i < 15; i++) begin
            exp_sb = (i % 5 == 4);
            sbuf_entry_i = ent(AW'(32'h100 + k * 4), DW'(32'hA0000000 + k), MW'(k + 5), LW'(k % 2));
            rd_addr_i = AW'(32'h0002000 + i * 4);
            rd_way_i  = LW'(i % 2);
            if (exp_sb)
                exp_q.push_back(wr_acc(AW'(32'h100 + k * 4), DW'(32'hA0000000 + k), MW'(k + 5), LW'(k % 2)));
            else
                exp_q.push_back(rd_acc(rd_addr_i, rd_way_i));
            @(negedge clk);
            n_cmp++;
            if ({rd_yumi_o, sbuf_yumi_o} !== {~exp_sb, exp_sb}) begin
                n_bad++; $display("FAIL starve_grant[%0d]: got %b, required %b", i, {rd_yumi_o, sbuf_yumi_o}, {~exp_sb, exp_sb});
            end
            if (exp_sb) k++;
            @(posedge clk); #1;
        end
        idle(2);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL starve_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_write_path();
        rd_v_i = 1'b0; sbuf_v_i = 1'b1; sbuf_empty_i = 1'b0;
        sbuf_entry_i = ent(28'h0000104, 32'hDEADBEEF, 4'b0101, 1'b1);
        exp_q.push_back(wr_acc(28'h0000104, 32'hDEADBEEF, 4'b0101, 1'b1));
        @(negedge clk);
        n_cmp++;
        if ({rd_yumi_o, sbuf_yumi_o} !== 2'b01) begin
            n_bad++; $display("FAIL write_grant: got %b, required 01", {rd_yumi_o, sbuf_yumi_o});
        end
        @(posedge clk); #1;
        sbuf_v_i = 1'b0; sbuf_empty_i = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (dm_addr_o !== 26'h0000041) begin
            n_bad++; $display("FAIL write_addr: got %h, required 0000041", dm_addr_o);
        end
        n_cmp++;
        if ({dm_w_o, dm_mask_o, dm_way_o} !== {1'b1, 4'b0101, 1'b1}) begin
            n_bad++; $display("FAIL write_ctrl: got %b, required 101011", {dm_w_o, dm_mask_o, dm_way_o});
        end
        @(posedge clk); #1;
        idle(1);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL write_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_flush_drain();
        logic [5:0] sv_p, emp_p, rd_p, sb_p, dn_p;
        logic [EW-1:0] ea, eb;
        sv_p = 6'b000111; emp_p = 6'b111000; rd_p = 6'b100001; sb_p = 6'b000110; dn_p = 6'b010000;
        ea = ent(28'h0000200, 32'h11111111, 4'hF, 1'b0);
        eb = ent(28'h000020C, 32'h22222222, 4'h3, 1'b1);
        rd_v_i = 1'b1; rd_way_i = 1'b0;
        for (int c = 0; c < 6; c++) begin
            flush_v_i    = (c < 5);
            sbuf_v_i     = sv_p[c];
            sbuf_empty_i = emp_p[c];
            sbuf_entry_i = (c < 2) ? ea : eb;
            rd_addr_i    = AW'(32'h0000300 + c * 4);
            if (rd_p[c]) exp_q.push_back(rd_acc(rd_addr_i, 1'b0));
            if (sb_p[c] && c == 1) exp_q.push_back(wr_acc(28'h0000200, 32'h11111111, 4'hF, 1'b0));
            if (sb_p[c] && c == 2) exp_q.push_back(wr_acc(28'h000020C, 32'h22222222, 4'h3, 1'b1));
            @(negedge clk);
            n_cmp++;
            if ({rd_yumi_o, sbuf_yumi_o, flush_done_o} !== {rd_p[c], sb_p[c], dn_p[c]}) begin
                n_bad++; $display("FAIL flush_drain[%0d]: got rd/sb/done %b, required %b", c,
                                  {rd_yumi_o, sbuf_yumi_o, flush_done_o}, {rd_p[c], sb_p[c], dn_p[c]});
            end
            @(posedge clk); #1;
        end
        idle(2);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL flush_drain_q: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_flush_empty();
        rd_v_i = 1'b0; sbuf_v_i = 1'b0; sbuf_empty_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            flush_v_i = (c < 3);
            @(negedge clk);
            n_cmp++;
            if ({flush_done_o, rd_yumi_o, sbuf_yumi_o} !== {(c == 2), 2'b00}) begin
                n_bad++; $display("FAIL flush_empty[%0d]: got done/rd/sb %b, required %b", c,
                                  {flush_done_o, rd_yumi_o, sbuf_yumi_o}, {(c == 2), 2'b00});
            end
            @(posedge clk); #1;
        end
        idle(1);
    endtask

    task automatic test_reset_flush();
        logic [7:0] rst_p, fl_p, rdv_p, rdy_p, sby_p;
        int h;
        rst_p = 8'b00000100; fl_p = 8'b00000111; rdv_p = 8'b11111000;
        rdy_p = 8'b01111000; sby_p = 8'b10000011;
        sbuf_v_i = 1'b1; sbuf_empty_i = 1'b0; rd_way_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            h = (c == 0) ? 0 : (c == 1) ? 1 : 2;
            reset_i   = rst_p[c];
            flush_v_i = fl_p[c];
            rd_v_i    = rdv_p[c];
            rd_addr_i = AW'(32'h0000500 + c * 4);
            sbuf_entry_i = ent(AW'(32'h400 + h * 8), DW'(32'hC0DE0000 + h), MW'(h + 1), LW'(h % 2));
            if (rdy_p[c]) exp_q.push_back(rd_acc(rd_addr_i, 1'b1));
            if (sby_p[c]) exp_q.push_back(wr_acc(AW'(32'h400 + h * 8), DW'(32'hC0DE0000 + h), MW'(h + 1), LW'(h % 2)));
            @(negedge clk);
            n_cmp++;
            if ({rd_yumi_o, sbuf_yumi_o, flush_done_o} !== {rdy_p[c], sby_p[c], 1'b0}) begin
                n_bad++; $display("FAIL reset_flush[%0d]: got rd/sb/done %b, required %b", c,
                                  {rd_yumi_o, sbuf_yumi_o, flush_done_o}, {rdy_p[c], sby_p[c], 1'b0});
            end
            if (c == 3) begin
                n_cmp++;
                if (dm_v_o !== 1'b0) begin
                    n_bad++; $display("FAIL reset_flush_dm_v: got %b, required 0", dm_v_o);
                end
            end
            @(posedge clk); #1;
        end
        reset_i = 1'b0;
        idle(2);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL reset_flush_q: got %0d pending, required 0", exp_q.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin
        reset_i = 1'b1; sbuf_v_i = 1'b0; sbuf_empty_i = 1'b1; rd_v_i = 1'b0; flush_v_i = 1'b0;
        sbuf_entry_i = '0; rd_addr_i = '0; rd_way_i = '0;
        test_reset();
        test_reads_only();
        test_starve();
        test_write_path();
        test_flush_drain();
        test_flush_empty();
        test_reset_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
